// File: rtl/lift_pkg.sv
// Shared definitions for the lift hall-call front end: button bit positions,
// floor encoding and the mapping from a serviced floor to the lamps it clears.
package lift_pkg;

    localparam int NUM_BTN = 6;

    localparam int BTN_U1 = 0;
    localparam int BTN_U2 = 1;
    localparam int BTN_U3 = 2;
    localparam int BTN_D2 = 3;
    localparam int BTN_D3 = 4;
    localparam int BTN_D4 = 5;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        FLOOR_1 = 2'b00,
        FLOOR_2 = 2'b01,
        FLOOR_3 = 2'b10,
        FLOOR_4 = 2'b11
    } floor_e;

    // Buttons answered when the lift finishes servicing floor f.
    function automatic logic [NUM_BTN-1:0] clear_mask(input floor_e f);
        logic [NUM_BTN-1:0] m;
        m = '0;
        case (f)
            FLOOR_1: m[BTN_U1] = 1'b1;
            FLOOR_2: begin
                m[BTN_U2] = 1'b1;
                m[BTN_D2] = 1'b1;
            end
            FLOOR_3: begin
                m[BTN_U3] = 1'b1;
                m[BTN_D3] = 1'b1;
            end
            FLOOR_4: m[BTN_D4] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One hall button: 2-FF synchronizer, counter-based debounce and a
// combinational rise flag that is high on the edge where db goes 0 -> 1.
module btn_debounce
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1;
    logic             s2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Rise is flagged on the same edge that accepts the new high level, so the
    // top can register press alongside db.
    assign rise = s2 & ~db & cnt_done;

    // Synchronize the raw input and accept a new level only after it has held
    // for DEBOUNCE_CYCLES consecutive synchronized cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt_done) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hall_button_conditioner.sv
// Hall-call button front end: debounces six buttons, issues one request pulse
// per accepted press and holds a call lamp until the lift services the floor.
module hall_button_conditioner
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic [1:0]          floor,
    input  logic                done,
    output logic [NUM_BTN-1:0]  press,
    output logic [NUM_BTN-1:0]  lamp
);

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] clear;
    logic [NUM_BTN-1:0] press_next;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .rise (rise[i])
        );
    end

    // Clear wins over a coincident rise: that call is already being serviced.
    always_comb begin
        clear = '0;
        if (done) begin
            clear = clear_mask(floor_e'(floor));
        end
        press_next = rise & ~lamp & ~clear;
    end

    // A lit lamp suppresses further requests so the buffer never sees duplicates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= '0;
            lamp  <= '0;
        end else begin
            press <= press_next;
            lamp  <= (lamp | press_next) & ~clear;
        end
    end

endmodule

// File: tb/tb_hall_button_conditioner.sv
// Directed bench for hall_button_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_hall_button_conditioner;

    logic       clk;
    logic       rst;
    logic [5:0] btn_raw;
    logic [1:0] floor;
    logic       done;
    logic [5:0] press;
    logic [5:0] lamp;

    int n_checks;
    int n_errors;

    hall_button_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .floor   (floor),
        .done    (done),
        .press   (press),
        .lamp    (lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Tick n times, summing press bits seen under mask.
    task automatic run_count(input int n, input logic [5:0] mask, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += $countones(press & mask);
        end
    endtask

    // Buttons already driven at this negedge: press appears after the 6th
    // rising edge and lasts one cycle.
    task automatic expect_press(input string tag, input logic [5:0] exp_press,
                                input logic [5:0] exp_lamp);
        int p;
        run_count(5, 6'h3F, p);
        check({tag, "_early"}, p, 0);
        tick();
        check({tag, "_press"}, press, exp_press);
        check({tag, "_lamp"}, lamp, exp_lamp);
        tick();
        check({tag, "_one_cycle"}, press, 6'h00);
    endtask

    initial begin
        int p;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        btn_raw  = 6'h3F;
        floor    = 2'b00;
        done     = 1'b0;

        // Reset holds outputs low even with every button pressed.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rst_press", press, 6'h00);
            check("rst_lamp", lamp, 6'h00);
        end

        // Release reset holding d3 only.
        btn_raw = 6'b010000;
        rst     = 1'b0;
        expect_press("d3", 6'b010000, 6'b010000);
        run_count(6, 6'h3F, p);
        check("d3_held_no_repeat", p, 0);

        // Service floor 3 clears d3.
        done  = 1'b1;
        floor = 2'b10;
        tick();
        check("d3_cleared", lamp, 6'h00);
        done    = 1'b0;
        btn_raw = 6'h00;
        run_count(10, 6'h3F, p);
        check("d3_release_quiet", p, 0);

        // Bounce on u2: 3 high, 1 low, 3 high, then low.
        btn_raw[1] = 1'b1;
        run_count(3, 6'h3F, p);
        btn_raw[1] = 1'b0;
        run_count(1, 6'h3F, p);
        btn_raw[1] = 1'b1;
        run_count(3, 6'h3F, p);
        btn_raw[1] = 1'b0;
        run_count(8, 6'h3F, p);
        check("u2_bounce_no_press", p, 0);
        check("u2_bounce_no_lamp", lamp, 6'h00);
        btn_raw[1] = 1'b1;
        expect_press("u2", 6'b000010, 6'b000010);

        // u1 press, release, press again while lit: no second request.
        btn_raw[0] = 1'b1;
        expect_press("u1", 6'b000001, 6'b000011);
        btn_raw[0] = 1'b0;
        run_count(12, 6'h3F, p);
        btn_raw[0] = 1'b1;
        run_count(15, 6'b000001, p);
        check("u1_dup_suppressed", p, 0);
        check("u1_dup_lamp", lamp, 6'b000011);
        done  = 1'b1;
        floor = 2'b00;
        tick();
        check("u1_cleared", lamp, 6'b000010);
        done    = 1'b0;
        btn_raw = 6'b000010;

        // d2 and u3 together; then floor 2 clears u2 and d2 but not u3.
        btn_raw[3] = 1'b1;
        btn_raw[2] = 1'b1;
        expect_press("d2u3", 6'b001100, 6'b001110);
        done  = 1'b1;
        floor = 2'b01;
        tick();
        check("floor2_clear", lamp, 6'b000100);
        done = 1'b0;

        // done with floor 4 and no d4 lamp lit changes nothing.
        done  = 1'b1;
        floor = 2'b11;
        tick();
        check("floor4_no_match", lamp, 6'b000100);
        done = 1'b0;

        // floor ignored while done is low.
        floor = 2'b10;
        tick();
        check("done_low_ignored", lamp, 6'b000100);
        done = 1'b1;
        tick();
        check("floor3_clear", lamp, 6'h00);
        done    = 1'b0;
        btn_raw = 6'h00;
        run_count(12, 6'h3F, p);
        check("release_all_quiet", p, 0);

        // Collision: u3 rise on the same edge as floor-3 service.
        btn_raw[2] = 1'b1;
        run_count(5, 6'h3F, p);
        check("coll_early", p, 0);
        done  = 1'b1;
        floor = 2'b10;
        tick();
        check("coll_press", press, 6'h00);
        check("coll_lamp", lamp, 6'h00);
        done = 1'b0;
        run_count(10, 6'h3F, p);
        check("coll_held_no_press", p, 0);
        check("coll_held_lamp", lamp, 6'h00);
        btn_raw = 6'h00;
        run_count(12, 6'h3F, p);

        // u1 and d4 rise together.
        btn_raw = 6'b100001;
        expect_press("u1d4", 6'b100001, 6'b100001);

        // Reset mid-count on d2; it must debounce from scratch afterwards.
        btn_raw[3] = 1'b1;
        run_count(3, 6'h3F, p);
        check("d2_precount_quiet", p, 0);
        rst = 1'b1;
        tick();
        check("midrst_lamp", lamp, 6'h00);
        check("midrst_press", press, 6'h00);
        btn_raw = 6'b001000;
        rst     = 1'b0;
        expect_press("d2_after_rst", 6'b001000, 6'b001000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hall_button_conditioner.md
# hall_button_conditioner

Front-end stage that feeds the lift's request buffer. It synchronizes and debounces the six raw hall-call buttons (u1, u2, u3, d2, d3, d4), converts each clean press into a single-cycle request pulse, and keeps a per-button call lamp lit until the lift services that floor. Its press outputs connect bit-for-bit to the buffer's u1/u2/u3/d2/d3/d4 inputs. Its floor/done inputs tap the lift FSM's `out` and `done`.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a new level must hold before it is accepted; legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, not overridden.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_raw  in  6  raw buttons, asynchronous, active-high; bit0 u1, bit1 u2, bit2 u3, bit3 d2, bit4 d3, bit5 d4.
- floor  in  2  current lift floor from the lift FSM; 2'b00 = floor 1 … 2'b11 = floor 4.
- done  in  1  lift FSM "floor serviced" strobe; qualifies `floor`.
- press  out  6  one-cycle request pulse per button, same bit order; drives the buffer inputs.
- lamp  out  6  call lamp per button, same bit order.

## Operation
- Per button: 2-FF synchronizer (s1→s2), debounced state `db`, counter `cnt`.
- Counter: if s2 == db, cnt ← 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1, then db ← s2 and cnt ← 0; else cnt ← cnt+1. Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles restarts the count and never changes db.
- Rise event: db transitions 0→1. A falling db produces no event.
- Clear event for floor f = done && floor == f. Bit mapping:
  - floor 1 clears bit0 (u1).
  - floor 2 clears bit1 (u2) and bit3 (d2).
  - floor 3 clears bit2 (u3) and bit4 (d3).
  - floor 4 clears bit5 (d4).
- press[i] (registered) = rise[i] && !lamp[i] && !clear[i]. A lit button never re-issues a request, so the buffer sees no duplicates.
- lamp[i] next state: 0 if clear[i]; else 1 if press[i] is being issued; else hold.
- Simultaneous rise and clear on the same button: clear wins. No press and no lamp; that request is already being serviced.
- Buttons operate independently. Any number of press bits may assert in the same cycle.

## Timing
- Reset values: press = 6'b0, lamp = 6'b0. s1, s2, db and cnt are all 0.
- Press latency: raw 1 first sampled at edge k. press[i] is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+1, for one cycle only. lamp[i] sets at that same edge.
- Release latency: db falls DEBOUNCE_CYCLES+2 edges after raw release. No output changes.
- Clear latency: done/floor sampled at edge j. lamp drops at edge j, visible the cycle after.
- Holding a button while the lift services that floor does not re-request. A new press needs release → debounced low → debounced high.
- Reset mid-operation: all state clears immediately. A button held through reset release is a fresh rise and gives press after the full latency.
- done ignored when no lamp matches. floor is ignored when done is low.

## Structure
- Shared package `lift_pkg`:
  - button index constants (BTN_U1=0 … BTN_D4=5);
  - floor encoding constants;
  - DEBOUNCE_CYCLES default;
  - a function mapping floor → 6-bit clear mask.
- Sub-module `btn_debounce`: synchronizer + counter + db + rise output, parameterized by DEBOUNCE_CYCLES. It is instantiated 6×.
- Top level holds the clear mask, the press/lamp registers and the gating.

## Test plan
- Reset: assert rst with btn_raw = 6'h3F → press = 0, lamp = 0 throughout. Release rst, hold d3 → press = 6'b010000 for one cycle, 6 edges after the first sample; lamp[4] = 1.
- Bounce, DEBOUNCE_CYCLES = 4: toggle u2 high 3 cycles, low 1, high 3 → no press. Then hold high → single press[1] pulse; lamp = 6'b000010.
- Duplicate suppression: press u1, release, press u1 again with lamp[0] lit → only one press pulse total. Then done = 1, floor = 2'b00 → lamp[0] clears next cycle.
- Floor-2 service: lamps u2 and d2 lit (6'b001010); done with floor = 2'b01 → lamp = 0 in both bits; lamp[2] (u3) unaffected if lit.
- Collision: u3 debounced rise on the same edge as done with floor = 2'b10 → press[2] stays 0, lamp[2] stays 0.
- Simultaneous: u1 and d4 rise together → press = 6'b100001 in one cycle. Assert rst mid-count on a third button → no pulse from it until re-debounced.
